// File: rtl/cntr_seq_pkg.sv
// Shared types and defaults for the sequenced counter (cntr_seq_ctrl).
package cntr_seq_pkg;

    localparam int CNTR_WIDTH_DEF = 4;
    localparam int STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } state_e;

endpackage

// File: rtl/cntr_seq_ctrl_if.sv
// Control/status bundle of cntr_seq_ctrl; master drives commands, slave is the controller.
interface cntr_seq_ctrl_if #(
    parameter int WIDTH = cntr_seq_pkg::CNTR_WIDTH_DEF
);
    logic             start;
    logic             pause;
    logic             resume;
    logic             abort;
    logic             dir;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    modport master (
        output start, pause, resume, abort, dir, load_val, term_val,
        input  count, busy, done, state
    );

    modport slave (
        input  start, pause, resume, abort, dir, load_val, term_val,
        output count, busy, done, state
    );
endinterface

// File: rtl/cntr_core.sv
// Counter datapath: synchronous load has priority over enabled up/down step (wraps modulo 2^WIDTH).
module cntr_core #(
    parameter int WIDTH = cntr_seq_pkg::CNTR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cntr_seq_ctrl.sv
// Run/pause/abort sequencer around cntr_core.
// Optional: CNTR_SEQ_CTRL_AUTORELOAD_EN reloads load_val on terminal match and stays in RUN.
module cntr_seq_ctrl
    import cntr_seq_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    cntr_seq_ctrl_if.slave  bus
);
    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic             dir_q;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] term_q;

    logic             core_load;
    logic             core_en;
    logic [WIDTH-1:0] core_val;
    logic [WIDTH-1:0] count;
    logic             at_term;

    assign at_term = (count == term_q);

    // Counter commands: abort beats terminal match beats pause.
    always_comb begin
        core_load = 1'b0;
        core_en   = 1'b0;
        core_val  = load_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    core_load = 1'b1;
                    core_val  = bus.load_val;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    core_load = 1'b1;
                    core_val  = '0;
                end else if (at_term) begin
`ifdef CNTR_SEQ_CTRL_AUTORELOAD_EN
                    core_load = 1'b1;
                    core_val  = load_q;
`endif
                end else if (!bus.pause) begin
                    core_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (bus.abort) begin
                    core_load = 1'b1;
                    core_val  = '0;
                end
            end
            default: ;
        endcase
    end

    cntr_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_val),
        .en       (core_en),
        .dir      (dir_q),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            load_q  <= '0;
            term_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        dir_q   <= bus.dir;
                        load_q  <= bus.load_val;
                        term_q  <= bus.term_val;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_term) begin
                        done_q <= 1'b1;
`ifndef CNTR_SEQ_CTRL_AUTORELOAD_EN
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
`endif
                    end else if (bus.pause) begin
                        state_q <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (bus.resume) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count = count;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Directed, table-driven bench for cntr_seq_ctrl (both default and autoreload builds).
module tb_cntr_seq_ctrl;
    import cntr_seq_pkg::*;

    localparam int W = 4;
    localparam logic [2:0] SI = 3'd0, SR = 3'd1, SP = 3'd2, SD = 3'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cntr_seq_ctrl_if #(.WIDTH(W)) bus ();

    cntr_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      tag;
        logic       start, pause, resume, abort, dir;
        logic [3:0] lv, tv;
        logic [3:0] ec;
        logic [2:0] es;
        logic       eb, ed;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input string tag, input logic st, input logic pa, input logic re,
                       input logic ab, input logic dr, input logic [3:0] lv, input logic [3:0] tv,
                       input logic [3:0] ec, input logic [2:0] es, input logic eb, input logic ed);
        vec_t v;
        v.tag = tag; v.start = st; v.pause = pa; v.resume = re; v.abort = ab; v.dir = dr;
        v.lv = lv; v.tv = tv; v.ec = ec; v.es = es; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic pa, input logic re, input logic ab,
                         input logic dr, input logic [3:0] lv, input logic [3:0] tv);
        bus.start = st; bus.pause = pa; bus.resume = re; bus.abort = ab;
        bus.dir = dr; bus.load_val = lv; bus.term_val = tv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] ec, input logic [2:0] es,
                             input logic eb, input logic ed);
        chk({tag, ".count"}, 32'(bus.count), 32'(ec));
        chk({tag, ".state"}, 32'(bus.state), 32'(es));
        chk({tag, ".busy"},  32'(bus.busy),  32'(eb));
        chk({tag, ".done"},  32'(bus.done),  32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen;
        logic [3:0] exp_cnt;

        // Vector table: inputs held for one edge, outputs checked just after it.
`ifdef CNTR_SEQ_CTRL_AUTORELOAD_EN
        add("ar_start",  1,0,0,0,0, 0,2,  0,SR,1,0);
        add("ar_1",      0,0,0,0,0, 9,9,  1,SR,1,0);
        add("ar_2",      0,0,0,0,0, 9,9,  2,SR,1,0);
        add("ar_reload", 0,0,0,0,0, 9,9,  0,SR,1,1);
        add("ar_1b",     0,0,0,0,0, 9,9,  1,SR,1,0);
        add("ar_2b",     0,0,0,0,0, 9,9,  2,SR,1,0);
        add("ar_pterm",  0,1,0,0,0, 9,9,  0,SR,1,1);
        add("ar_1c",     1,0,0,0,1, 9,9,  1,SR,1,0);
        add("ar_abort",  0,0,0,1,0, 9,9,  0,SI,0,0);
`else
        add("a_start",   1,0,0,0,1, 5,2,  5,SR,1,0);
        add("a_4",       0,0,0,0,0, 9,9,  4,SR,1,0);
        add("a_3",       0,0,0,0,0, 9,9,  3,SR,1,0);
        add("a_2",       0,0,0,0,0, 9,9,  2,SR,1,0);
        add("a_done",    0,0,0,0,0, 9,9,  2,SD,0,1);
        add("a_hold",    0,0,0,0,0, 9,9,  2,SD,0,0);
        add("b_start",   1,0,0,0,0, 14,1, 14,SR,1,0);
        add("b_15",      0,0,0,0,0, 0,0,  15,SR,1,0);
        add("b_wrap0",   0,0,0,0,0, 0,0,  0,SR,1,0);
        add("b_1",       0,0,0,0,0, 0,0,  1,SR,1,0);
        add("b_done",    0,0,0,0,0, 0,0,  1,SD,0,1);
        add("b_hold",    0,0,0,0,0, 0,0,  1,SD,0,0);
        add("c_start",   1,0,0,0,0, 1,9,  1,SR,1,0);
        add("c_2",       0,0,0,0,0, 0,0,  2,SR,1,0);
        add("c_3",       0,0,0,0,0, 0,0,  3,SR,1,0);
        add("c_pause",   0,1,0,0,0, 0,0,  3,SP,1,0);
        add("c_p2",      0,1,0,0,0, 0,0,  3,SP,1,0);
        add("c_p3",      0,0,0,0,0, 0,0,  3,SP,1,0);
        add("c_p4st",    1,0,0,0,1, 0,0,  3,SP,1,0);
        add("c_resume",  0,0,1,0,0, 0,0,  3,SR,1,0);
        add("c_4",       0,0,0,0,0, 0,0,  4,SR,1,0);
        add("c_st_ign",  1,0,0,0,1, 0,0,  5,SR,1,0);
        add("c_res_ign", 0,0,1,0,0, 0,0,  6,SR,1,0);
        add("c_pause2",  0,1,0,0,0, 0,0,  6,SP,1,0);
        add("c_abort",   0,0,1,1,0, 0,0,  0,SI,0,0);
        add("c_idle_ign",0,1,1,1,0, 0,0,  0,SI,0,0);
        add("d_start",   1,0,0,0,0, 7,7,  7,SR,1,0);
        add("d_done",    0,0,0,0,0, 7,7,  7,SD,0,1);
        add("d_hold",    0,0,0,0,0, 7,7,  7,SD,0,0);
        add("e_start",   1,0,0,0,1, 1,14, 1,SR,1,0);
        add("e_0",       0,0,0,0,0, 0,0,  0,SR,1,0);
        add("e_15",      0,0,0,0,0, 0,0,  15,SR,1,0);
        add("e_14",      0,0,0,0,0, 0,0,  14,SR,1,0);
        add("e_pterm",   0,1,0,0,0, 0,0,  14,SD,0,1);
        add("f_start",   1,0,0,0,0, 3,2,  3,SR,1,0);
        add("f_abpause", 0,1,0,1,0, 0,0,  0,SI,0,0);
        add("f_idle",    0,0,0,0,0, 0,0,  0,SI,0,0);
`endif

        // Reset held two cycles, then released.
        drive(0,0,0,0,0,0,0);
        rst = 1'b1;
        step();
        step();
        check_out("rst_hold", 0, SI, 0, 0);
        rst = 1'b0;
        step();
        check_out("rst_rel", 0, SI, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].pause, vecs[i].resume, vecs[i].abort,
                  vecs[i].dir, vecs[i].lv, vecs[i].tv);
            step();
            check_out(vecs[i].tag, vecs[i].ec, vecs[i].es, vecs[i].eb, vecs[i].ed);
        end

        // Reset mid-run at count 7, with start and abort asserted alongside.
        drive(0,0,0,0,0,0,0);
        step();
        drive(1,0,0,0,0,5,12);
        step();
        check_out("r_start", 5, SR, 1, 0);
        drive(0,0,0,0,0,0,0);
        step();
        step();
        check_out("r_7", 7, SR, 1, 0);
        drive(1,1,0,1,1,9,9);
        rst = 1'b1;
        step();
        check_out("r_rst", 0, SI, 0, 0);
        rst = 1'b0;
        drive(1,0,0,0,0,2,3);
        step();
        check_out("r_after", 2, SR, 1, 0);
        drive(0,0,0,0,0,0,0);
        step();
        check_out("r_3", 3, SR, 1, 0);
        step();
`ifdef CNTR_SEQ_CTRL_AUTORELOAD_EN
        check_out("r_term", 2, SR, 1, 1);
        drive(0,0,0,1,0,0,0);
        step();
        check_out("r_abort", 0, SI, 0, 0);
`else
        check_out("r_term", 3, SD, 0, 1);
`endif

        // Long up run: bounded wait for done, checking latency and final count.
        drive(1,0,0,0,0,0,10);
        step();
        drive(0,0,0,0,0,0,0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            step();
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("w_seen", 32'(seen), 32'd1);
        chk("w_latency", 32'(cyc), 32'd11);
`ifdef CNTR_SEQ_CTRL_AUTORELOAD_EN
        exp_cnt = 4'd0;
`else
        exp_cnt = 4'd10;
`endif
        chk("w_count", 32'(bus.count), 32'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cntr_seq_ctrl.md
CNTR_SEQ_CTRL -- requirements
Module: cntr_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin a count run; honoured only in IDLE or DONE.
REQ-005 pause  in  1  freeze counting while in RUN.
REQ-006 resume  in  1  continue counting from PAUSE.
REQ-007 abort  in  1  terminate the run from RUN or PAUSE.
REQ-008 dir  in  1  0 = up, 1 = down; sampled only on accepted start.
REQ-009 load_val  in  WIDTH  start value; sampled only on accepted start.
REQ-010 term_val  in  WIDTH  terminal value; sampled only on accepted start.
REQ-011 count  out  WIDTH  current counter value.
REQ-012 busy  out  1  high in RUN or PAUSE.
REQ-013 done  out  1  one-cycle pulse on reaching the terminal value.
REQ-014 state  out  3  encoded FSM state, for debug.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE and DONE.
REQ-016 An accepted start at edge N SHALL make count = load_val and state = RUN at N+1, and SHALL capture dir, load_val and term_val into registers.
REQ-017 start SHALL be ignored in RUN and PAUSE; changes to dir, load_val or term_val SHALL NOT affect a run in progress.
REQ-018 In RUN with count != term_val, count SHALL step +1 (up) or -1 (down) per cycle, modulo 2^WIDTH (up: 15->0, down: 0->15 for WIDTH=4).
REQ-019 In RUN with count == term_val, the next cycle SHALL have state = DONE, done = 1 for exactly one cycle, and count holding term_val.
REQ-020 load_val == term_val SHALL give done one cycle after entering RUN.
REQ-021 In RUN, pause SHALL move the FSM to PAUSE with count held. In PAUSE, resume SHALL return it to RUN, and counting SHALL continue on the following edge.
REQ-022 abort in RUN or PAUSE SHALL force IDLE with count = 0 on the next cycle; done SHALL stay 0.
REQ-023 Priority within one cycle SHALL be: rst > abort > terminal match > pause. A pause coinciding with a terminal match SHALL yield DONE.
REQ-024 pause and resume SHALL be ignored outside RUN and PAUSE respectively.
REQ-025 DONE SHALL hold count and accept a new start exactly as IDLE does.

Reset
REQ-026 rst SHALL give state = IDLE, count = 0, busy = 0, done = 0 and clear the captured registers, from any state including mid-run.
REQ-027 rst SHALL override any input asserted in the same cycle.

Configuration
REQ-028 With CNTR_SEQ_CTRL_AUTORELOAD_EN defined, a terminal match in RUN SHALL pulse done, reload count with the captured load_val and remain in RUN; DONE becomes unreachable except via no path.
REQ-029 Without CNTR_SEQ_CTRL_AUTORELOAD_EN, behaviour SHALL be exactly REQ-019.

Structure
REQ-030 Package cntr_seq_pkg SHALL hold the state enum, its 3-bit encoding and the WIDTH default.
REQ-031 Counter datapath SHALL be sub-module cntr_core with inputs clk, rst, load, load_val, en and dir and output count. cntr_seq_ctrl SHALL sequence it.

Verification
REQ-032 rst high 2 cycles, then low -> count=0, state=IDLE, busy=0, done=0.
REQ-033 start, dir=1, load_val=5, term_val=2 -> count sequence 5,4,3,2; done pulses one cycle after count=2; state=DONE with count holding 2.
REQ-034 start, dir=0, load_val=14, term_val=1 -> count sequence 14,15,0,1 (wrap-around), then done.
REQ-035 During an up run at count=3, pause for 4 cycles then resume -> count holds 3 while paused, then 4; start pulsed mid-run has no effect.
REQ-036 abort in PAUSE -> IDLE, count=0, no done. rst at count=7 mid-run -> IDLE, count=0 next cycle.
REQ-037 With the macro defined: load_val=0, term_val=2, up -> sequence 0,1,2, done pulse, then 0,1,2 repeating with busy held at 1.
